// File: rtl/alu_pkg.sv
// Shared ALU encodings: opcode values and the serial sequencer state encoding.
package alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, time-shared by the serial add/subtract sequencer.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: one full_adder, LSB first, one bit per clock.
//   state   | meaning
//   IDLE    | waiting for start, operands captured on accept
//   RUN     | one operand bit per clock through the shared adder
//   DONE    | one-cycle done pulse, result and flags valid
module serial_addsub_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH-2:0]   r_res_sr;
  logic               r_c;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_result;
  logic               r_carry;
  logic               r_overflow;
  logic               r_zero;
  logic               r_negative;
  logic               w_sum;
  logic               w_cout;
  logic               w_last;
  logic [WIDTH-1:0]   w_res_nxt;

  full_adder u_fa (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .cin  (r_c),
    .sum  (w_sum),
    .cout (w_cout)
  );

  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_res_nxt = {w_sum, r_res_sr};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr     <= '0;
      r_b_sr     <= '0;
      r_res_sr   <= '0;
      r_c        <= 1'b0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
      r_negative <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (start) begin
        // SUB is a + ~b + 1: invert b and seed the carry with 1.
        r_a_sr <= a;
        r_b_sr <= (op == OP_SUB) ? ~b : b;
        r_c    <= (op == OP_SUB);
        r_cnt  <= '0;
      end
    end else if (r_state == ST_RUN) begin
      r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
      r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
      r_res_sr <= w_res_nxt[WIDTH-1:1];
      r_c      <= w_cout;
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) begin
        // r_c still holds the carry into the MSB on this edge.
        r_result   <= w_res_nxt;
        r_carry    <= w_cout;
        r_overflow <= r_c ^ w_cout;
        r_zero     <= (w_res_nxt == '0);
        r_negative <= w_sum;
      end
    end
  end

  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DONE);
  assign result   = r_result;
  assign carry    = r_carry;
  assign overflow = r_overflow;
  assign zero     = r_zero;
  assign negative = r_negative;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench for serial_addsub_ctrl: arithmetic reference model plus acceptance/timing model.
module tb_serial_addsub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, carry, overflow, zero, negative;
  logic [W-1:0] result;

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carry(carry),
    .overflow(overflow), .zero(zero), .negative(negative)
  );

  always #5 clk = ~clk;

  typedef struct {
    int res;
    int cy;
    int ov;
    int zf;
    int nf;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   m_busy = 0;
  int   n_done = 0;
  int   last_done_cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int ux, uy, sx, sy, sr;
    ux = int'(x); uy = int'(y);
    sx = (ux >= 128) ? ux - 256 : ux;
    sy = (uy >= 128) ? uy - 256 : uy;
    if (o) begin
      e.res = (ux - uy + 256) % 256;
      e.cy  = (ux >= uy) ? 1 : 0;
      sr    = sx - sy;
    end else begin
      e.res = (ux + uy) % 256;
      e.cy  = (ux + uy >= 256) ? 1 : 0;
      sr    = sx + sy;
    end
    e.ov  = (sr > 127 || sr < -128) ? 1 : 0;
    e.zf  = (e.res == 0) ? 1 : 0;
    e.nf  = (e.res >= 128) ? 1 : 0;
    e.cyc = 0;
    return e;
  endfunction

  // Acceptance model: idle for one sample, then busy for WIDTH+1 edges.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0;
      q.delete();
    end else begin
      exp_t e;
      cyc++;
      if (m_busy > 0) m_busy--;
      else if (start) begin
        e = model(op, a, b);
        e.cyc = cyc + W;
        q.push_back(e);
        m_busy = W + 1;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    chk("busy", int'(busy), (m_busy > 0) ? 1 : 0);
    if (done) begin
      n_done++;
      last_done_cyc = cyc;
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("result", int'(result), e.res);
        chk("carry", int'(carry), e.cy);
        chk("overflow", int'(overflow), e.ov);
        chk("zero", int'(zero), e.zf);
        chk("negative", int'(negative), e.nf);
      end
    end
  end

  task automatic wait_done(output int ok);
    int k;
    for (k = 0; k < 4 * W && !done; k++) @(negedge clk);
    ok = (k < 4 * W) ? 1 : 0;
    chk("done_timeout", ok, 1);
  endtask

  task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int er, input int ec, input int eo, input int ez, input int en);
    int ok;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    wait_done(ok);
    if (ok != 0) begin
      chk("dir_result", int'(result), er);
      chk("dir_carry", int'(carry), ec);
      chk("dir_overflow", int'(overflow), eo);
      chk("dir_zero", int'(zero), ez);
      chk("dir_negative", int'(negative), en);
    end
    @(negedge clk);
  endtask

  initial begin
    int ok, c1, d0, seen;
    logic [W-1:0] seen_res;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_flags", int'({carry, overflow, zero, negative}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(1'b0, 8'h7F, 8'h01, 8'h80, 0, 1, 0, 1);
    run_op(1'b0, 8'hFF, 8'h01, 8'h00, 1, 0, 1, 0);
    run_op(1'b1, 8'h05, 8'h07, 8'hFE, 0, 0, 0, 1);
    run_op(1'b1, 8'h80, 8'h01, 8'h7F, 1, 1, 0, 0);

    // Ignored starts and operand changes during an ADD.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 8'h12; b = 8'h34;
    d0 = n_done; seen = 0; seen_res = '0;
    for (int i = 1; i <= W + 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); op = 1'($urandom);
      if (done) begin seen++; seen_res = result; end
      if (i == 2 || i == W) start = 1'b1;
    end
    start = 1'b0;
    chk("ignore_done_count", n_done - d0, 1);
    chk("ignore_seen", seen, 1);
    chk("ignore_result", int'(seen_res), 8'h46);

    // Asynchronous reset part-way through an ADD.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 8'hFF; b = 8'hFF;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_result", int'(result), 0);
    chk("arst_flags", int'({carry, overflow, zero, negative}), 0);
    d0 = n_done;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 2) @(negedge clk);
    chk("arst_no_done", n_done - d0, 0);
    run_op(1'b0, 8'h12, 8'h34, 8'h46, 0, 0, 0, 0);

    // start held high: back-to-back operations.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 8'h01; b = 8'h02;
    wait_done(ok);
    c1 = cyc;
    @(negedge clk);
    wait_done(ok);
    chk("b2b_spacing", cyc - c1, W + 2);
    start = 1'b0;
    repeat (W + 4) @(negedge clk);

    // Randomized traffic; acceptance decided by the bench's own model.
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) != 0);
      op = 1'($urandom);
      case ($urandom_range(0, 7))
        0: a = 8'h00;
        1: a = 8'hFF;
        2: a = 8'h80;
        3: a = 8'h7F;
        default: a = W'($urandom);
      endcase
      b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
    end
    start = 1'b0;
    repeat (3 * W) @(negedge clk);
    chk("queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
